pixel_mem_arbiter: RTL and testbench



---
 rtl/pixel_mem_pkg.sv | 28 ++
 rtl/pixel_mem_arbiter_rd_tag_pipe.sv | 43 ++++
 rtl/pixel_mem_arbiter.sv | 116 +++++++++++
 tb/tb_pixel_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : pixel_mem_pkg
// Brief  : Shared types and defaults for the pixel memory arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pixel_mem_pkg;

  // Bit 1 marks a CPU read, bit 0 a VGA read; the tag pipe relies on this.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'b00,
    TAG_VGA_RD = 2'b01,
    TAG_CPU_RD = 2'b10
  } req_tag_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_VGA  = 2'b10
  } grant_t;

  localparam int c_mem_lat_default    = 1;
  localparam int c_starve_max_default = 16;

endpackage

`default_nettype wire

// File: rtl/pixel_mem_arbiter_rd_tag_pipe.sv
//------------------------------------------------------------------------------
// Module : rd_tag_pipe
// Brief  : MEM_LAT-deep read tag shift register producing the rvalid strobes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_tag_pipe
  import pixel_mem_pkg::*;
#(
  parameter int MEM_LAT = c_mem_lat_default
) (
  input  logic     clk,
  input  logic     rst,
  input  req_tag_t tag_in,
  output logic     cpu_rvalid,
  output logic     vga_rvalid
);

  req_tag_t r_stage [MEM_LAT];

  generate
    for (genvar i = 0; i < MEM_LAT; i++) begin : g_stage
      if (i == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_stage[i] <= TAG_NONE;
          else     r_stage[i] <= tag_in;
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_stage[i] <= TAG_NONE;
          else     r_stage[i] <= r_stage[i-1];
        end
      end
    end
  endgenerate

  assign cpu_rvalid = r_stage[MEM_LAT-1][1];
  assign vga_rvalid = r_stage[MEM_LAT-1][0];

endmodule

`default_nettype wire

// File: rtl/pixel_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : pixel_mem_arbiter
// Brief  : Single-port pixel RAM arbiter between CPU load/store and VGA reads.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_mem_arbiter
  import pixel_mem_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = c_mem_lat_default,
  parameter int STARVE_MAX = c_starve_max_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
  input  logic              vga_req,
  input  logic              vga_active,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                c_cnt_w      = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  grant_t             w_grant;
  req_tag_t           w_tag;
  logic [c_cnt_w-1:0] w_wait_nxt;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_last_vga;
  logic               r_starved;

  // Grants are held off while rst is high so every output reads 0 in reset.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst) begin
      if (cpu_req && vga_req) begin
        if (vga_active || !r_last_vga) w_grant = GNT_VGA;
        else                           w_grant = GNT_CPU;
      end else if (cpu_req) begin
        w_grant = GNT_CPU;
      end else if (vga_req) begin
        w_grant = GNT_VGA;
      end
    end
  end

  assign cpu_gnt   = (w_grant == GNT_CPU);
  assign vga_gnt   = (w_grant == GNT_VGA);
  assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

  assign mem_en    = cpu_gnt | vga_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : (vga_gnt ? vga_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;

  always_comb begin
    w_tag = TAG_NONE;
    if (cpu_gnt && !cpu_we) w_tag = TAG_CPU_RD;
    else if (vga_gnt)       w_tag = TAG_VGA_RD;
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!cpu_req || cpu_gnt)           w_wait_nxt = '0;
    else if (r_wait_cnt != c_starve_max) w_wait_nxt = r_wait_cnt + c_cnt_w'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_vga <= 1'b1;
      r_wait_cnt <= '0;
      r_starved  <= 1'b0;
    end else begin
      if (cpu_gnt)      r_last_vga <= 1'b0;
      else if (vga_gnt) r_last_vga <= 1'b1;
      r_wait_cnt <= w_wait_nxt;
      r_starved  <= (w_wait_nxt == c_starve_max);
    end
  end

  assign cpu_starved = r_starved;

  rd_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_in     (w_tag),
    .cpu_rvalid (cpu_rvalid),
    .vga_rvalid (vga_rvalid)
  );

endmodule

`default_nettype wire

// File: tb/tb_pixel_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_pixel_mem_arbiter
// Brief  : Directed bench for pixel_mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pixel_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vga_req = 1'b0, vga_active = 1'b0;
  logic [16:0] cpu_addr = '0, vga_addr = '0;
  logic [7:0]  cpu_wdata = '0;

  logic        cpu_gnt_1, cpu_stall_1, cpu_rvalid_1, cpu_starved_1;
  logic        vga_gnt_1, vga_rvalid_1, mem_en_1, mem_we_1;
  logic [7:0]  cpu_rdata_1, vga_rdata_1, mem_wdata_1, mem_rdata_1;
  logic [16:0] mem_addr_1;
  logic        cpu_gnt_3, cpu_stall_3, cpu_rvalid_3, cpu_starved_3;
  logic        vga_gnt_3, vga_rvalid_3, mem_en_3, mem_we_3;
  logic [7:0]  cpu_rdata_3, vga_rdata_3, mem_wdata_3, mem_rdata_3;
  logic [16:0] mem_addr_3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pixel_mem_arbiter #(.ADDR_W(17), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_1), .cpu_stall(cpu_stall_1), .cpu_rvalid(cpu_rvalid_1),
    .cpu_rdata(cpu_rdata_1), .cpu_starved(cpu_starved_1),
    .vga_req(vga_req), .vga_active(vga_active), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt_1), .vga_rvalid(vga_rvalid_1), .vga_rdata(vga_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );

  pixel_mem_arbiter #(.ADDR_W(17), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_3), .cpu_stall(cpu_stall_3), .cpu_rvalid(cpu_rvalid_3),
    .cpu_rdata(cpu_rdata_3), .cpu_starved(cpu_starved_3),
    .vga_req(vga_req), .vga_active(vga_active), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt_3), .vga_rvalid(vga_rvalid_3), .vga_rdata(vga_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
  );

  // RAM model: unwritten locations read as addr[7:0] ^ 0xB5 (0x10 -> 0xA5).
  logic [7:0] ram_val [0:131071];
  logic       ram_wr  [0:131071];
  logic [7:0] rd1, rd3a, rd3b, rd3c;

  function automatic logic [7:0] rd_model(input logic [16:0] a);
    return (ram_wr[a] === 1'b1) ? ram_val[a] : (a[7:0] ^ 8'hB5);
  endfunction

  always @(posedge clk) begin
    if (mem_en_1 && mem_we_1) begin
      ram_val[mem_addr_1] <= mem_wdata_1;
      ram_wr[mem_addr_1]  <= 1'b1;
    end
    rd1  <= rd_model(mem_addr_1);
    rd3a <= rd_model(mem_addr_3);
    rd3b <= rd3a;
    rd3c <= rd3b;
  end

  assign mem_rdata_1 = rd1;
  assign mem_rdata_3 = rd3c;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle before checks.
  task automatic set_in(input logic creq, input logic cwe, input logic [16:0] caddr,
                        input logic [7:0] cwd, input logic vreq, input logic vact,
                        input logic [16:0] vaddr);
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vga_req = vreq; vga_active = vact; vga_addr = vaddr;
    #1;
  endtask

  initial begin
    // Reset state, with a CPU request already pending
    set_in(1, 0, 17'h10, 8'h00, 1, 0, 17'h0);
    chk_b("rst_cpu_gnt", cpu_gnt_1, 1'b0);
    chk_b("rst_vga_gnt", vga_gnt_1, 1'b0);
    chk_b("rst_mem_en", mem_en_1, 1'b0);
    chk_b("rst_mem_we", mem_we_1, 1'b0);
    chk_b("rst_rvalid", cpu_rvalid_1 | vga_rvalid_1, 1'b0);
    chk_b("rst_starved", cpu_starved_1, 1'b0);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    @(negedge clk); rst = 1'b0;

    // CPU load only, MEM_LAT=1
    set_in(1, 0, 17'h10, 8'h00, 0, 0, 17'h0);
    chk_b("ld_cpu_gnt", cpu_gnt_1, 1'b1);
    chk_b("ld_mem_en", mem_en_1, 1'b1);
    chk_b("ld_mem_we", mem_we_1, 1'b0);
    chk_v("ld_mem_addr", 32'(mem_addr_1), 32'h10);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("ld_cpu_rvalid", cpu_rvalid_1, 1'b1);
    chk_v("ld_cpu_rdata", 32'(cpu_rdata_1), 32'hA5);
    chk_b("ld_vga_rvalid", vga_rvalid_1, 1'b0);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("ld_rvalid_once", cpu_rvalid_1, 1'b0);

    // VGA fixed priority during active video; CPU starves after 4 waits
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 17'h20, 8'h00, 1, 1, 17'h100);
      chk_b("pri_vga_gnt", vga_gnt_1, 1'b1);
      chk_b("pri_cpu_gnt", cpu_gnt_1, 1'b0);
      chk_b("pri_cpu_stall", cpu_stall_1, 1'b1);
      chk_b("pri_starved", cpu_starved_1, k == 4);
      chk_b("pri_vga_rvalid", vga_rvalid_1, k != 0);
      if (k != 0) chk_v("pri_vga_rdata", 32'(vga_rdata_1), 32'hB5);
    end
    set_in(1, 0, 17'h20, 8'h00, 0, 1, 17'h100);
    chk_b("pri_cpu_gnt_late", cpu_gnt_1, 1'b1);
    chk_b("pri_stall_clear", cpu_stall_1, 1'b0);
    chk_b("pri_starved_held", cpu_starved_1, 1'b1);
    set_in(0, 0, 17'h0, 8'h00, 0, 1, 17'h0);
    chk_b("pri_starved_clear", cpu_starved_1, 1'b0);
    chk_b("pri_cpu_rvalid", cpu_rvalid_1, 1'b1);
    chk_v("pri_cpu_rdata", 32'(cpu_rdata_1), 32'h95);

    // Round-robin: make VGA the last grant, then contend continuously
    set_in(0, 0, 17'h30, 8'h00, 1, 0, 17'h40);
    chk_b("rr_vga_first", vga_gnt_1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 17'h30, 8'h00, 1, 0, 17'h40);
      chk_b("rr_cpu_gnt", cpu_gnt_1, (i % 2) == 0);
      chk_b("rr_vga_gnt", vga_gnt_1, (i % 2) == 1);
      chk_b("rr_vga_rvalid", vga_rvalid_1, (i % 2) == 0);
      chk_b("rr_cpu_rvalid", cpu_rvalid_1, (i % 2) == 1);
      if ((i % 2) == 1) chk_v("rr_cpu_rdata", 32'(cpu_rdata_1), 32'h85);
      else              chk_v("rr_vga_rdata", 32'(vga_rdata_1), 32'hF5);
    end
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("rr_vga_rvalid_tail", vga_rvalid_1, 1'b1);
    chk_b("rr_cpu_rvalid_tail", cpu_rvalid_1, 1'b0);

    // CPU store at the top address while VGA is idle
    set_in(1, 1, 17'h1FFFF, 8'h3C, 0, 0, 17'h0);
    chk_b("st_cpu_gnt", cpu_gnt_1, 1'b1);
    chk_b("st_mem_en", mem_en_1, 1'b1);
    chk_b("st_mem_we", mem_we_1, 1'b1);
    chk_v("st_mem_addr", 32'(mem_addr_1), 32'h1FFFF);
    chk_v("st_mem_wdata", 32'(mem_wdata_1), 32'h3C);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("st_no_rvalid", cpu_rvalid_1 | vga_rvalid_1, 1'b0);

    // MEM_LAT=3: back-to-back VGA, CPU, VGA reads
    for (int i = 0; i < 4; i++) set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    set_in(0, 0, 17'h0, 8'h00, 1, 1, 17'h211);
    chk_b("l3_vga_gnt0", vga_gnt_3, 1'b1);
    set_in(1, 0, 17'h22, 8'h00, 0, 1, 17'h0);
    chk_b("l3_cpu_gnt1", cpu_gnt_3, 1'b1);
    set_in(0, 0, 17'h0, 8'h00, 1, 1, 17'h233);
    chk_b("l3_vga_gnt2", vga_gnt_3, 1'b1);
    chk_b("l3_no_early", cpu_rvalid_3 | vga_rvalid_3, 1'b0);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("l3_c3_vga", vga_rvalid_3, 1'b1);
    chk_b("l3_c3_cpu", cpu_rvalid_3, 1'b0);
    chk_v("l3_c3_data", 32'(vga_rdata_3), 32'hA4);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("l3_c4_cpu", cpu_rvalid_3, 1'b1);
    chk_b("l3_c4_vga", vga_rvalid_3, 1'b0);
    chk_v("l3_c4_data", 32'(cpu_rdata_3), 32'h97);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("l3_c5_vga", vga_rvalid_3, 1'b1);
    chk_b("l3_c5_cpu", cpu_rvalid_3, 1'b0);
    chk_v("l3_c5_data", 32'(vga_rdata_3), 32'h86);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    chk_b("l3_c6_idle", cpu_rvalid_3 | vga_rvalid_3, 1'b0);

    // Reset with two reads in flight
    set_in(1, 0, 17'h10, 8'h00, 0, 0, 17'h0);
    set_in(0, 0, 17'h0, 8'h00, 1, 0, 17'h40);
    @(negedge clk);
    cpu_req = 1'b1; vga_req = 1'b1;
    #1;
    chk_b("pre_rst_vga_rvalid", vga_rvalid_1, 1'b1);
    rst = 1'b1;
    #1;
    chk_b("arst_grants", cpu_gnt_1 | vga_gnt_1 | cpu_gnt_3 | vga_gnt_3, 1'b0);
    chk_b("arst_mem_en", mem_en_1 | mem_en_3, 1'b0);
    chk_b("arst_stall", cpu_stall_1, 1'b0);
    chk_b("arst_rvalid", vga_rvalid_1 | cpu_rvalid_1, 1'b0);
    set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 17'h0, 8'h00, 0, 0, 17'h0);
      chk_b("post_rst_rvalid",
            cpu_rvalid_1 | vga_rvalid_1 | cpu_rvalid_3 | vga_rvalid_3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
